pll_reset_sequencer: RTL

//  Drives the PLL RST input, watches the asynchronous PLL LOCK output and issues the core system reset.

---
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor running on the board oscillator clock.
// Pulses the PLL reset, qualifies a stable lock and only then releases the core system reset.
module pll_reset_sequencer #(
   parameter int PLL_RESET_CYCLES   = 4,
   parameter int LOCK_TIMEOUT       = 4096,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int RESET_HOLD_CYCLES  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pllLocked,
   input  logic       softReset,
   input  logic       softPllReset,
   output logic       pllReset,
   output logic       systemReset,
   output logic       ready,
   output logic [2:0] state,
   output logic [7:0] lockLossCount,
   output logic [7:0] retryCount
);

   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_HOLD      = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TIMER_W = $clog2(MAX_CYC + 1);

   localparam logic [TIMER_W-1:0] PLL_RESET_LAST = TIMER_W'(PLL_RESET_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST    = TIMER_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LAST      = TIMER_W'(RESET_HOLD_CYCLES - 1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               sync_meta_q;
   logic               lock_sync_q;
   logic [7:0]         loss_cnt_q, loss_cnt_d;
   logic [7:0]         retry_cnt_q, retry_cnt_d;
   logic               pll_reset_q, pll_reset_d;
   logic               system_reset_q, system_reset_d;
   logic               ready_q, ready_d;
   logic               restart;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_PLL_RESET;
         timer_q        <= '0;
         sync_meta_q    <= 1'b0;
         lock_sync_q    <= 1'b0;
         loss_cnt_q     <= 8'd0;
         retry_cnt_q    <= 8'd0;
         pll_reset_q    <= 1'b1;
         system_reset_q <= 1'b1;
         ready_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         sync_meta_q    <= pllLocked;
         lock_sync_q    <= sync_meta_q;
         loss_cnt_q     <= loss_cnt_d;
         retry_cnt_q    <= retry_cnt_d;
         pll_reset_q    <= pll_reset_d;
         system_reset_q <= system_reset_d;
         ready_q        <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      loss_cnt_d  = loss_cnt_q;
      retry_cnt_d = retry_cnt_q;
      restart     = 1'b0;
      timer_d     = (state_q == ST_RUN) ? '0 : timer_q + TIMER_W'(1);

      // A software PLL restart overrides every lock event and suppresses counting.
      if (softPllReset) begin
         state_d = ST_PLL_RESET;
         restart = 1'b1;
      end else begin
         case (state_q)
            ST_PLL_RESET: begin
               if (timer_q == PLL_RESET_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_sync_q) begin
                  state_d = ST_STABILIZE;
               end else if (timer_q == TIMEOUT_LAST) begin
                  state_d     = ST_PLL_RESET;
                  retry_cnt_d = (retry_cnt_q == 8'hFF) ? retry_cnt_q : retry_cnt_q + 8'd1;
               end
            end
            ST_STABILIZE: begin
               if (!lock_sync_q) state_d = ST_WAIT_LOCK;
               else if (timer_q == STABLE_LAST) state_d = ST_HOLD;
            end
            ST_HOLD: begin
               if (!lock_sync_q) state_d = ST_WAIT_LOCK;
               else if (timer_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!lock_sync_q) begin
                  state_d    = ST_WAIT_LOCK;
                  loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
               end else if (softReset) begin
                  state_d = ST_HOLD;
               end
            end
            default: state_d = ST_PLL_RESET;
         endcase
      end

      if (restart || (state_d != state_q)) timer_d = '0;
   end

   // Outputs decode the next state so the registered copies line up with state_q.
   always_comb begin
      pll_reset_d    = (state_d == ST_PLL_RESET);
      system_reset_d = (state_d != ST_RUN);
      ready_d        = (state_d == ST_RUN);
   end

   assign pllReset      = pll_reset_q;
   assign systemReset   = system_reset_q;
   assign ready         = ready_q;
   assign state         = state_q;
   assign lockLossCount = loss_cnt_q;
   assign retryCount    = retry_cnt_q;

endmodule
